// File: rtl/capture_ctrl_if.sv
// Capture controller bus: config/trigger/dump handshakes in,
// RAM write/read strobes and status out.
interface capture_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4
);
    logic [1:0]        mode;
    logic              start;
    logic              adc_vld;
    logic [DEC_W-1:0]  decimator;
    logic              trig;
    logic [ADDR_W-1:0] trig_pos;
    logic              clr_cap_done;
    logic              dump_req;
    logic              dump_ack;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              rd_en;
    logic [ADDR_W-1:0] raddr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic [ADDR_W-1:0] trace_end;
    logic              dump_done;
    logic              busy;

    modport master (
        input  mode, start, adc_vld, decimator, trig, trig_pos,
        input  clr_cap_done, dump_req, dump_ack,
        output we, waddr, rd_en, raddr, armed, triggered,
        output capture_done, trace_end, dump_done, busy
    );

    modport slave (
        output mode, start, adc_vld, decimator, trig, trig_pos,
        output clr_cap_done, dump_req, dump_ack,
        input  we, waddr, rd_en, raddr, armed, triggered,
        input  capture_done, trace_end, dump_done, busy
    );
endinterface

// File: rtl/capture_ctrl.sv
// Scope capture controller: decimated circular trace capture with
// pre/post-trigger split, normal/auto/single-shot modes and dump.
module capture_ctrl #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DEC_W      = 4,
    parameter int AUTO_TO    = 1024
) (
    input logic            clk,
    input logic            rst_n,
    capture_ctrl_if.master bus
);
    localparam int ADDR_W = DEPTH_LOG2;
    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int DCW    = 2**DEC_W - 1;
    localparam int ACW    = $clog2(AUTO_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_DUMP
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [DCW-1:0]    r_dec_cnt;
    logic [ADDR_W:0]   r_smpl_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ACW-1:0]    r_auto_cnt;
    logic [ADDR_W-1:0] r_dump_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_trace_end;
    logic              r_rd_en;
    logic              r_armed;
    logic              r_triggered;
    logic              r_done;
    logic              r_dump_done;
    logic              r_busy;

    logic [DCW-1:0]    w_dec_max;
    logic              w_keep;
    logic              w_cap;
    logic              w_we;
    logic              w_off;
    logic [ADDR_W:0]   w_smpl_nxt;
    logic              w_pre_full;
    logic [ACW-1:0]    w_auto_nxt;
    logic              w_take;
    logic              w_post_hit;
    logic              w_dump_last;
    logic              w_enter_pre;

    assign w_dec_max = {DCW{1'b1}} >> (DCW - int'(bus.decimator));
    assign w_keep    = bus.adc_vld && (r_dec_cnt == w_dec_max);
    assign w_cap     = (r_state == S_PRE) || (r_state == S_ARMED)
                    || (r_state == S_POST);
    assign w_we      = w_keep && w_cap;
    assign w_off     = (bus.mode == 2'b00);

    // Thresholds include the write of the current cycle.
    assign w_smpl_nxt = r_smpl_cnt + (ADDR_W+1)'(w_we);
    assign w_pre_full = ({1'b0, w_smpl_nxt} + (ADDR_W+2)'(bus.trig_pos))
                     >= (ADDR_W+2)'(DEPTH);
    assign w_auto_nxt = r_auto_cnt + ACW'(w_we);
    assign w_take     = bus.trig || ((bus.mode == 2'b10)
                     && (w_auto_nxt >= ACW'(AUTO_TO)));
    assign w_post_hit = w_we
                     && ((r_post_cnt + ADDR_W'(1)) == bus.trig_pos);
    assign w_dump_last = bus.dump_ack
                      && (r_dump_cnt == ADDR_W'(DEPTH - 1));

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !w_off) w_nxt = S_PRE;
            end
            S_PRE: begin
                if (w_off)           w_nxt = S_IDLE;
                else if (w_pre_full) w_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_off) w_nxt = S_IDLE;
                else if (w_take)
                    w_nxt = (bus.trig_pos == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (w_off)           w_nxt = S_IDLE;
                else if (w_post_hit) w_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.dump_req) w_nxt = S_DUMP;
                else if (bus.clr_cap_done)
                    w_nxt = (bus.mode == 2'b01 || bus.mode == 2'b10)
                          ? S_PRE : S_IDLE;
            end
            S_DUMP: begin
                if (w_dump_last) w_nxt = S_DONE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_enter_pre = (w_nxt == S_PRE) && (r_state != S_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dec_cnt   <= '0;
            r_smpl_cnt  <= '0;
            r_post_cnt  <= '0;
            r_auto_cnt  <= '0;
            r_dump_cnt  <= '0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_trace_end <= '0;
            r_rd_en     <= 1'b0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_dump_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_armed     <= (w_nxt == S_ARMED);
            r_triggered <= (w_nxt == S_POST);
            r_done      <= (w_nxt == S_DONE) || (w_nxt == S_DUMP);
            r_busy      <= (w_nxt != S_IDLE);
            r_dump_done <= 1'b0;

            if (bus.adc_vld)
                r_dec_cnt <= w_keep ? '0 : r_dec_cnt + DCW'(1);

            if (w_we) begin
                r_trace_end <= r_waddr;
                r_waddr     <= r_waddr + ADDR_W'(1);
            end
            if (w_we && r_state == S_PRE)
                r_smpl_cnt <= w_smpl_nxt;
            if (w_we && r_state == S_ARMED
                && r_auto_cnt < ACW'(AUTO_TO))
                r_auto_cnt <= w_auto_nxt;
            if (w_we && r_state == S_POST)
                r_post_cnt <= r_post_cnt + ADDR_W'(1);

            // Re-entry to PRE restarts the trace from address 0.
            if (w_enter_pre) begin
                r_dec_cnt  <= '0;
                r_smpl_cnt <= '0;
                r_post_cnt <= '0;
                r_auto_cnt <= '0;
                r_waddr    <= '0;
            end

            if (r_state == S_DONE && w_nxt == S_DUMP) begin
                r_raddr    <= r_trace_end + ADDR_W'(1);
                r_rd_en    <= 1'b1;
                r_dump_cnt <= '0;
            end
            if (r_state == S_DUMP && bus.dump_ack) begin
                r_raddr    <= r_raddr + ADDR_W'(1);
                r_dump_cnt <= r_dump_cnt + ADDR_W'(1);
                if (w_dump_last) begin
                    r_rd_en     <= 1'b0;
                    r_dump_done <= 1'b1;
                end
            end
        end
    end

    assign bus.we           = w_we;
    assign bus.waddr        = r_waddr;
    assign bus.rd_en        = r_rd_en;
    assign bus.raddr        = r_raddr;
    assign bus.armed        = r_armed;
    assign bus.triggered    = r_triggered;
    assign bus.capture_done = r_done;
    assign bus.trace_end    = r_trace_end;
    assign bus.dump_done    = r_dump_done;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: table-driven capture phases plus
// hand sequences for dump, re-arm and mid-capture reset.
module tb_capture_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    capture_ctrl_if #(.ADDR_W(9), .DEC_W(4)) bus ();

    capture_ctrl #(
        .DEPTH_LOG2(9),
        .DEC_W     (4),
        .AUTO_TO   (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] dec;
        logic [8:0] tp;
        logic       start;
        logic       adc;
        logic       trig;
        logic       clr;
        int         n;
        int         wr;
        logic [3:0] fl;
        int         wa;
        int         te;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic [1:0] mode, input logic [3:0] dec,
                       input logic [8:0] tp, input logic start,
                       input logic adc, input logic trig,
                       input logic clr, input int n, input int wr,
                       input logic [3:0] fl, input int wa,
                       input int te);
        row_t r;
        r.mode = mode; r.dec = dec; r.tp = tp; r.start = start;
        r.adc = adc; r.trig = trig; r.clr = clr; r.n = n;
        r.wr = wr; r.fl = fl; r.wa = wa; r.te = te;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int flags();
        return int'({bus.busy, bus.armed, bus.triggered,
                     bus.capture_done});
    endfunction

    task automatic idle_inputs();
        bus.start = 0; bus.adc_vld = 0; bus.trig = 0;
        bus.clr_cap_done = 0; bus.dump_req = 0; bus.dump_ack = 0;
    endtask

    // Apply rows lo..hi; called at a negedge, returns at a negedge.
    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            int wr;
            wr = 0;
            bus.mode = tbl[k].mode;
            bus.decimator = tbl[k].dec;
            bus.trig_pos = tbl[k].tp;
            bus.start = tbl[k].start;
            bus.adc_vld = tbl[k].adc;
            bus.trig = tbl[k].trig;
            bus.clr_cap_done = tbl[k].clr;
            for (int c = 0; c < tbl[k].n; c++) begin
                #2;
                if (bus.we) wr++;
                @(negedge clk);
            end
            idle_inputs();
            chk($sformatf("row%0d writes", k), wr, tbl[k].wr);
            chk($sformatf("row%0d flags", k), flags(), int'(tbl[k].fl));
            chk($sformatf("row%0d waddr", k), int'(bus.waddr), tbl[k].wa);
            chk($sformatf("row%0d trace_end", k),
                int'(bus.trace_end), tbl[k].te);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " we"}, int'(bus.we), 0);
        chk({tag, " waddr"}, int'(bus.waddr), 0);
        chk({tag, " rd_en"}, int'(bus.rd_en), 0);
        chk({tag, " raddr"}, int'(bus.raddr), 0);
        chk({tag, " flags"}, flags(), 0);
        chk({tag, " trace_end"}, int'(bus.trace_end), 0);
        chk({tag, " dump_done"}, int'(bus.dump_done), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 0;
        bus.mode = 2'b00;
        bus.decimator = '0;
        bus.trig_pos = '0;
        idle_inputs();

        // Rows 0-7: normal mode, trig_pos 100, trigger on write 600
        add(2'b01, 0, 100, 1, 0, 0, 0,   1,   0, 4'b1000,   0,   0);
        add(2'b01, 0, 100, 0, 1, 0, 0, 411, 411, 4'b1000, 411, 410);
        add(2'b01, 0, 100, 0, 1, 0, 0,   1,   1, 4'b1100, 412, 411);
        add(2'b01, 0, 100, 0, 1, 0, 0, 187, 187, 4'b1100,  87,  86);
        add(2'b01, 0, 100, 0, 1, 1, 0,   1,   1, 4'b1010,  88,  87);
        add(2'b01, 0, 100, 0, 1, 0, 0,  99,  99, 4'b1010, 187, 186);
        add(2'b01, 0, 100, 0, 1, 0, 0,   1,   1, 4'b1001, 188, 187);
        add(2'b01, 0, 100, 0, 1, 0, 0,   5,   0, 4'b1001, 188, 187);
        // Rows 8-14: single-shot, decimator 3, trig_pos 500
        add(2'b11, 3, 500, 1, 0, 0, 0,   1,   0, 4'b1000,   0, 187);
        add(2'b11, 3, 500, 0, 1, 0, 0,   7,   0, 4'b1000,   0, 187);
        add(2'b11, 3, 500, 0, 1, 0, 0,   1,   1, 4'b1000,   1,   0);
        add(2'b11, 3, 500, 0, 1, 0, 0,  80,  10, 4'b1000,  11,  10);
        add(2'b11, 3, 500, 0, 1, 0, 0,   8,   1, 4'b1100,  12,  11);
        add(2'b11, 3, 500, 0, 1, 0, 0,   4,   0, 4'b1100,  12,  11);
        add(2'b11, 3, 500, 0, 0, 1, 0,   1,   0, 4'b1010,  12,  11);
        // Rows 15-20: single-shot, trig_pos 0, waddr wrap
        add(2'b11, 0,   0, 1, 0, 0, 0,   1,   0, 4'b1000,   0,   0);
        add(2'b11, 0,   0, 0, 1, 0, 0, 511, 511, 4'b1000, 511, 510);
        add(2'b11, 0,   0, 0, 1, 0, 0,   1,   1, 4'b1100,   0, 511);
        add(2'b11, 0,   0, 0, 1, 0, 0,   3,   3, 4'b1100,   3,   2);
        add(2'b11, 0,   0, 0, 1, 1, 0,   1,   1, 4'b1001,   4,   3);
        add(2'b11, 0,   0, 0, 0, 0, 1,   1,   0, 4'b0000,   4,   3);
        // Rows 21-27: auto mode forced trigger, re-arm, mode off
        add(2'b10, 0, 100, 1, 0, 0, 0,   1,   0, 4'b1000,   0,   3);
        add(2'b10, 0, 100, 0, 1, 0, 0, 412, 412, 4'b1100, 412, 411);
        add(2'b10, 0, 100, 0, 1, 0, 0,  15,  15, 4'b1100, 427, 426);
        add(2'b10, 0, 100, 0, 1, 0, 0,   1,   1, 4'b1010, 428, 427);
        add(2'b10, 0, 100, 0, 1, 0, 0, 100, 100, 4'b1001,  16,  15);
        add(2'b10, 0, 100, 0, 0, 0, 1,   1,   0, 4'b1000,   0,  15);
        add(2'b00, 0, 100, 0, 1, 0, 0,   1,   1, 4'b0000,   1,   0);

        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1;
        @(negedge clk);

        run_rows(0, 7);

        // Dump the normal-mode trace, oldest first
        bus.dump_req = 1;
        @(negedge clk);
        bus.dump_req = 0;
        chk("dump rd_en", int'(bus.rd_en), 1);
        chk("dump flags", flags(), 4'b1001);
        bus.dump_ack = 1;
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("raddr[%0d]", i), int'(bus.raddr),
                (188 + i) % 512);
            if (bus.dump_done) chk("early dump_done", 1, 0);
            bus.clr_cap_done = (i == 100);
            @(negedge clk);
        end
        bus.dump_ack = 0;
        bus.clr_cap_done = 0;
        chk("dump_done pulse", int'(bus.dump_done), 1);
        chk("rd_en drop", int'(bus.rd_en), 0);
        chk("back in DONE", flags(), 4'b1001);
        chk("raddr wrap", int'(bus.raddr), 188);
        @(negedge clk);
        chk("dump_done single", int'(bus.dump_done), 0);
        chk("still DONE", flags(), 4'b1001);

        // Normal-mode clear re-arms into PRE from address 0
        bus.clr_cap_done = 1;
        @(negedge clk);
        bus.clr_cap_done = 0;
        chk("rearm flags", flags(), 4'b1000);
        chk("rearm waddr", int'(bus.waddr), 0);
        bus.mode = 2'b00;
        @(negedge clk);
        chk("off flags", flags(), 4'b0000);

        run_rows(8, 14);

        // Asynchronous reset while in POST
        #2;
        rst_n = 0;
        #1;
        chk_reset_vals("mid-POST reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        run_rows(15, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
